// File: rtl/branch_unit.sv
// Execute-stage branch resolver: flag-based conditional branches, CALL/RET through a
// circular return-address stack, and a one-cycle squash of the wrong-path instruction.
module branch_unit #(
    parameter  int DEPTH = 4,
    localparam int W     = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instrValid,
    input  logic [2:0]   branchOp,
    input  logic [7:0]   pc,
    input  logic [7:0]   target,
    input  logic         flagWe,
    input  logic         zeroIn,
    input  logic         carryIn,
    output logic [7:0]   branchTarget,
    output logic         branchEnable,
    output logic         squash,
    output logic [W-1:0] stackDepth,
    output logic         stackOverflow,
    output logic         stackUnderflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_JZ   = 3'b010;
    localparam logic [2:0] OP_JNZ  = 3'b011;
    localparam logic [2:0] OP_JC   = 3'b100;
    localparam logic [2:0] OP_CALL = 3'b101;
    localparam logic [2:0] OP_RET  = 3'b110;

    logic [7:0]    stack [DEPTH];
    logic [PW-1:0] ptr;          // next slot to write; top of stack is ptr-1
    logic [PW-1:0] top_idx;
    logic [PW-1:0] nxt_idx;
    logic [W-1:0]  depth;
    logic          zf, cf;
    logic          eff, taken, empty, full;
    logic          do_push, do_pop, do_unf;
    logic [7:0]    tgt;

    assign empty = (depth == '0);
    assign full  = (depth == W'(DEPTH));

    always_comb begin
        top_idx = (ptr == '0) ? PW'(DEPTH - 1) : ptr - PW'(1);
        nxt_idx = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    end

    always_comb begin
        eff   = instrValid & ~squash & rst;
        taken = 1'b0;
        tgt   = target;
        unique case (branchOp)
            OP_JMP:  taken = 1'b1;
            OP_JZ:   taken = zf;
            OP_JNZ:  taken = ~zf;
            OP_JC:   taken = cf;
            OP_CALL: taken = 1'b1;
            OP_RET: begin
                taken = ~empty;
                tgt   = stack[top_idx];
            end
            default: taken = 1'b0;
        endcase
        branchEnable = eff & taken;
        branchTarget = branchEnable ? tgt : 8'h00;
        do_push      = eff & (branchOp == OP_CALL);
        do_pop       = eff & (branchOp == OP_RET) & ~empty;
        do_unf       = eff & (branchOp == OP_RET) & empty;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            zf             <= 1'b0;
            cf             <= 1'b0;
            squash         <= 1'b0;
            ptr            <= '0;
            depth          <= '0;
            stackOverflow  <= 1'b0;
            stackUnderflow <= 1'b0;
        end else begin
            squash <= branchEnable;
            if (eff && flagWe) begin
                zf <= zeroIn;
                cf <= carryIn;
            end
            // A push onto a full stack overwrites the oldest slot; depth saturates.
            if (do_push) begin
                ptr <= nxt_idx;
                if (full) stackOverflow <= 1'b1;
                else      depth         <= depth + W'(1);
            end
            if (do_pop) begin
                ptr   <= top_idx;
                depth <= depth - W'(1);
            end
            if (do_unf) stackUnderflow <= 1'b1;
        end
    end

    // Entry contents need no reset: depth gates every read.
    always_ff @(posedge clk) begin
        if (do_push) stack[ptr] <= 8'(pc + 8'd1);
    end

    assign stackDepth = depth;

endmodule
